// File: rtl/spi_ram_slave_param_if.sv
// SPI pin bundle for spi_ram_slave_param: slave select, serial in/out and the abort flag.
interface spi_ram_slave_param_if;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic frame_abort;

    modport master (
        output SS_n,
        output MOSI,
        input  MISO,
        input  frame_abort
    );

    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO,
        output frame_abort
    );
endinterface

// File: rtl/spi_ram_slave_param.sv
// Parametrised SPI slave fronting a single-port RAM; SPI pins sampled on clk, one frame per SS_n low.
// Define SPI_AUTO_INC_EN to post-increment wr_addr on each write and rd_addr on each read.
module spi_ram_slave_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input logic                  clk,
    input logic                  reset,
    spi_ram_slave_param_if.slave bus_io
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW  = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StCmd, StRx, StRdWait, StTx, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [1:0]              cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]   rd_buf_q, rd_buf_d;
    logic                    miso_q, miso_d;
    logic                    abort_q, abort_d;

    logic [DATA_WIDTH-1:0]   mem_q [Depth];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   payload;
    logic                    mem_we;

    assign rd_word = mem_q[rd_addr_q];
    // Payload including the bit being sampled this cycle.
    assign payload = (shift_q << 1) | DATA_WIDTH'(bus_io.MOSI);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        shift_d   = shift_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        rd_buf_d  = rd_buf_q;
        miso_d    = 1'b0;
        abort_d   = 1'b0;
        mem_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!bus_io.SS_n) begin
                    state_d = StCmd;
                    cnt_d   = '0;
                end
            end
            StCmd: begin
                if (bus_io.SS_n) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else begin
                    cmd_d = {cmd_q[0], bus_io.MOSI};
                    if (cnt_q == CntOne) begin
                        cnt_d   = '0;
                        state_d = StRx;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end
            StRx: begin
                if (bus_io.SS_n) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else begin
                    shift_d = payload;
                    cnt_d   = cnt_q + CntOne;
                    if (cnt_q == LastBit) begin
                        cnt_d   = '0;
                        state_d = StDone;
                        unique case (cmd_q)
                            2'b00: wr_addr_d = payload[ADDR_WIDTH-1:0];
                            2'b01: begin
                                mem_we = 1'b1;
`ifdef SPI_AUTO_INC_EN
                                wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
`endif
                            end
                            2'b10: rd_addr_d = payload[ADDR_WIDTH-1:0];
                            default: state_d = StRdWait;
                        endcase
                    end
                end
            end
            StRdWait: begin
                if (bus_io.SS_n) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else begin
                    // MSB goes out on this edge; the rest is shifted from rd_buf.
                    rd_buf_d = rd_word;
                    miso_d   = rd_word[DATA_WIDTH-1];
                    cnt_d    = '0;
                    state_d  = StTx;
`ifdef SPI_AUTO_INC_EN
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
`endif
                end
            end
            StTx: begin
                if (bus_io.SS_n) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else if (cnt_q == LastBit) begin
                    state_d = StDone;
                end else begin
                    rd_buf_d = rd_buf_q << 1;
                    miso_d   = rd_buf_q[DATA_WIDTH-2];
                    cnt_d    = cnt_q + CntOne;
                end
            end
            StDone: begin
                if (bus_io.SS_n) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cmd_q     <= '0;
            shift_q   <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            rd_buf_q  <= '0;
            miso_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            shift_q   <= shift_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            rd_buf_q  <= rd_buf_d;
            miso_q    <= miso_d;
            abort_q   <= abort_d;
        end
    end

    // RAM contents survive reset; reset only blocks a write on its own edge.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[wr_addr_q] <= payload;
        end
    end

    assign bus_io.MISO        = miso_q;
    assign bus_io.frame_abort = abort_q;
endmodule

// File: tb/tb_spi_ram_slave_param.sv
// Self-checking bench for spi_ram_slave_param: an 8/8 instance and a 16/4 instance against a RAM model.
module tb_spi_ram_slave_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_ram_slave_param_if bus8 ();
    spi_ram_slave_param_if bus16 ();

    spi_ram_slave_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus8)
    );

    spi_ram_slave_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut16 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus16)
    );

    int checks = 0;
    int failures = 0;
    int ab8 = 0;
    int ab16 = 0;

    // Reference model: memory arrays plus current write/read addresses per instance.
    logic [15:0] m8 [256];
    logic [15:0] m16 [16];
    int wa [2];
    int ra [2];

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus8.frame_abort === 1'b1) ab8++;
        if (bus16.frame_abort === 1'b1) ab16++;
    endtask

    task automatic drive(input int sel, input logic ss, input logic mosi);
        if (sel == 0) begin
            bus8.SS_n = ss;
            bus8.MOSI = mosi;
        end else begin
            bus16.SS_n = ss;
            bus16.MOSI = mosi;
        end
    endtask

    function automatic logic miso(input int sel);
        return (sel == 0) ? bus8.MISO : bus16.MISO;
    endfunction

    task automatic model_reset();
        wa[0] = 0; wa[1] = 0; ra[0] = 0; ra[1] = 0;
    endtask

    task automatic model_apply(input int sel, input logic [1:0] cmd, input logic [15:0] data,
                               output logic [15:0] rd);
        int mask;
        mask = (sel == 0) ? 255 : 15;
        rd = '0;
        case (cmd)
            2'd0: wa[sel] = int'(data) & mask;
            2'd1: begin
                if (sel == 0) m8[wa[sel]] = data & 16'h00FF;
                else m16[wa[sel]] = data;
`ifdef SPI_AUTO_INC_EN
                wa[sel] = (wa[sel] + 1) & mask;
`endif
            end
            2'd2: ra[sel] = int'(data) & mask;
            default: begin
                rd = (sel == 0) ? m8[ra[sel]] : m16[ra[sel]];
`ifdef SPI_AUTO_INC_EN
                ra[sel] = (ra[sel] + 1) & mask;
`endif
            end
        endcase
    endtask

    // Runs one frame; cut >= 0 raises SS_n after that many payload bits. bad counts MISO
    // being non-zero outside the shift-out window.
    task automatic frame(input int sel, input logic [1:0] cmd, input logic [15:0] data,
                         input int cut, output logic [15:0] rx, output int bad);
        int w;
        w = (sel == 0) ? 8 : 16;
        rx = '0;
        bad = 0;
        drive(sel, 1'b0, 1'b0);
        tick();
        if (miso(sel) !== 1'b0) bad++;
        for (int i = 1; i >= 0; i--) begin
            drive(sel, 1'b0, cmd[i]);
            tick();
            if (miso(sel) !== 1'b0) bad++;
        end
        for (int i = 0; i < w; i++) begin
            if (i == cut) break;
            drive(sel, 1'b0, data[w-1-i]);
            tick();
            if (miso(sel) !== 1'b0) bad++;
        end
        if (cut < 0) begin
            if (cmd == 2'd3) begin
                drive(sel, 1'b0, 1'($urandom % 2));
                tick();
                for (int k = 0; k < w; k++) begin
                    rx[w-1-k] = miso(sel);
                    drive(sel, 1'b0, 1'($urandom % 2));
                    tick();
                end
                if (miso(sel) !== 1'b0) bad++;
            end
            repeat (2) begin
                drive(sel, 1'b0, 1'($urandom % 2));
                tick();
                if (miso(sel) !== 1'b0) bad++;
            end
        end
        drive(sel, 1'b1, 1'b0);
        tick();
        if (miso(sel) !== 1'b0) bad++;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b0);
        tick();
        tick();
        model_reset();
        checks++;
        if (bus8.MISO !== 1'b0) begin
            failures++;
            $display("FAIL reset_miso: got %b want 0", bus8.MISO);
        end
        checks++;
        if (bus8.frame_abort !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: got %b want 0", bus8.frame_abort);
        end
        reset = 1'b0;
        ab8 = 0;
        repeat (4) begin
            tick();
            checks++;
            if (bus8.MISO !== 1'b0 || bus16.MISO !== 1'b0) begin
                failures++;
                $display("FAIL idle_miso: got %b/%b want 0/0", bus8.MISO, bus16.MISO);
            end
        end
        checks++;
        if (ab8 != 0) begin
            failures++;
            $display("FAIL idle_abort: got %0d pulses want 0", ab8);
        end
    endtask

    task automatic test_basic_rw();
        logic [15:0] rx, exp;
        int bad, tot, a0;
        tot = 0;
        a0 = ab8;
        frame(0, 2'd0, 16'h07, -1, rx, bad); tot += bad; model_apply(0, 2'd0, 16'h07, exp);
        frame(0, 2'd1, 16'hA5, -1, rx, bad); tot += bad; model_apply(0, 2'd1, 16'hA5, exp);
        frame(0, 2'd2, 16'h07, -1, rx, bad); tot += bad; model_apply(0, 2'd2, 16'h07, exp);
        frame(0, 2'd3, 16'h00, -1, rx, bad); tot += bad; model_apply(0, 2'd3, 16'h00, exp);
        checks++;
        if (rx !== 16'h00A5) begin
            failures++;
            $display("FAIL basic_read: got %h want 00a5", rx);
        end
        checks++;
        if (rx !== exp) begin
            failures++;
            $display("FAIL basic_model: got %h want %h", rx, exp);
        end
        checks++;
        if (tot != 0 || ab8 != a0) begin
            failures++;
            $display("FAIL basic_quiet: got bad=%0d aborts=%0d want 0/0", tot, ab8 - a0);
        end
    endtask

    task automatic test_abort();
        logic [15:0] rx, exp;
        int bad, a0;
        a0 = ab8;
        frame(0, 2'd1, 16'h3C, 5, rx, bad);
        checks++;
        if (ab8 - a0 != 1) begin
            failures++;
            $display("FAIL abort_pulse: got %0d cycles want 1", ab8 - a0);
        end
        a0 = ab8;
        frame(0, 2'd2, 16'h07, -1, rx, bad); model_apply(0, 2'd2, 16'h07, exp);
        frame(0, 2'd3, 16'h00, -1, rx, bad); model_apply(0, 2'd3, 16'h00, exp);
        checks++;
        if (rx !== 16'h00A5 || rx !== exp) begin
            failures++;
            $display("FAIL abort_no_write: got %h want 00a5", rx);
        end
        checks++;
        if (ab8 != a0) begin
            failures++;
            $display("FAIL abort_spurious: got %0d pulses want 0", ab8 - a0);
        end
    endtask

    task automatic test_auto_inc();
        logic [15:0] rx1, rx2, exp1, exp2, e1, e2, dummy;
        int bad;
        frame(0, 2'd0, 16'hFF, -1, rx1, bad); model_apply(0, 2'd0, 16'hFF, dummy);
        frame(0, 2'd1, 16'h11, -1, rx1, bad); model_apply(0, 2'd1, 16'h11, dummy);
        frame(0, 2'd1, 16'h22, -1, rx1, bad); model_apply(0, 2'd1, 16'h22, dummy);
        frame(0, 2'd2, 16'hFF, -1, rx1, bad); model_apply(0, 2'd2, 16'hFF, dummy);
        frame(0, 2'd3, 16'h00, -1, rx1, bad); model_apply(0, 2'd3, 16'h00, exp1);
        frame(0, 2'd3, 16'h00, -1, rx2, bad); model_apply(0, 2'd3, 16'h00, exp2);
`ifdef SPI_AUTO_INC_EN
        e1 = 16'h0011; e2 = 16'h0022;
`else
        e1 = 16'h0022; e2 = 16'h0022;
`endif
        checks++;
        if (rx1 !== e1 || rx1 !== exp1) begin
            failures++;
            $display("FAIL autoinc_read1: got %h want %h", rx1, e1);
        end
        checks++;
        if (rx2 !== e2 || rx2 !== exp2) begin
            failures++;
            $display("FAIL autoinc_read2: got %h want %h", rx2, e2);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [15:0] rx, exp, dummy;
        logic [2:0] top;
        int bad, a0;
        frame(0, 2'd0, 16'h00, -1, rx, bad); model_apply(0, 2'd0, 16'h00, dummy);
        frame(0, 2'd1, 16'h5A, -1, rx, bad); model_apply(0, 2'd1, 16'h5A, dummy);
        frame(0, 2'd2, 16'h07, -1, rx, bad); model_apply(0, 2'd2, 16'h07, dummy);
        a0 = ab8;
        drive(0, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 1'b1); tick();
        drive(0, 1'b0, 1'b1); tick();
        repeat (8) tick();
        tick();
        top[2] = bus8.MISO; tick();
        top[1] = bus8.MISO; tick();
        top[0] = bus8.MISO;
        reset = 1'b1;
        tick();
        checks++;
        if (top !== 3'b101) begin
            failures++;
            $display("FAIL midtx_bits: got %b want 101", top);
        end
        checks++;
        if (bus8.MISO !== 1'b0) begin
            failures++;
            $display("FAIL midtx_miso: got %b want 0", bus8.MISO);
        end
        reset = 1'b0;
        drive(0, 1'b1, 1'b0);
        tick();
        tick();
        model_reset();
        checks++;
        if (ab8 != a0) begin
            failures++;
            $display("FAIL midtx_abort: got %0d pulses want 0", ab8 - a0);
        end
        frame(0, 2'd3, 16'h00, -1, rx, bad); model_apply(0, 2'd3, 16'h00, exp);
        checks++;
        if (rx !== 16'h005A || rx !== exp) begin
            failures++;
            $display("FAIL midtx_rdaddr0: got %h want 005a", rx);
        end
        frame(0, 2'd1, 16'hC3, -1, rx, bad); model_apply(0, 2'd1, 16'hC3, dummy);
        frame(0, 2'd2, 16'h00, -1, rx, bad); model_apply(0, 2'd2, 16'h00, dummy);
        frame(0, 2'd3, 16'h00, -1, rx, bad); model_apply(0, 2'd3, 16'h00, exp);
        checks++;
        if (rx !== 16'h00C3 || rx !== exp) begin
            failures++;
            $display("FAIL midtx_wraddr0: got %h want 00c3", rx);
        end
        frame(0, 2'd2, 16'h07, -1, rx, bad); model_apply(0, 2'd2, 16'h07, dummy);
        frame(0, 2'd3, 16'h00, -1, rx, bad); model_apply(0, 2'd3, 16'h00, exp);
        checks++;
        if (rx !== 16'h00A5 || rx !== exp) begin
            failures++;
            $display("FAIL midtx_ram_kept: got %h want 00a5", rx);
        end
    endtask

    task automatic test_wide();
        logic [15:0] rx, exp, dummy;
        int bad, tot;
        tot = 0;
        frame(1, 2'd0, 16'hFFF3, -1, rx, bad); tot += bad; model_apply(1, 2'd0, 16'hFFF3, dummy);
        frame(1, 2'd1, 16'hBEEF, -1, rx, bad); tot += bad; model_apply(1, 2'd1, 16'hBEEF, dummy);
        frame(1, 2'd2, 16'h0003, -1, rx, bad); tot += bad; model_apply(1, 2'd2, 16'h0003, dummy);
        frame(1, 2'd3, 16'h0000, -1, rx, bad); tot += bad; model_apply(1, 2'd3, 16'h0000, exp);
        checks++;
        if (rx !== 16'hBEEF || rx !== exp) begin
            failures++;
            $display("FAIL wide_read: got %h want beef", rx);
        end
        checks++;
        if (tot != 0 || ab16 != 0) begin
            failures++;
            $display("FAIL wide_quiet: got bad=%0d aborts=%0d want 0/0", tot, ab16);
        end
    endtask

    task automatic test_random();
        logic [15:0] rx, exp, dummy, a, d;
        int bad, a0;
        for (int it = 0; it < 24; it++) begin
            a = 16'($urandom);
            d = 16'($urandom_range(0, 255));
            frame(0, 2'd0, a, -1, rx, bad); model_apply(0, 2'd0, a, dummy);
            frame(0, 2'd1, d, -1, rx, bad); model_apply(0, 2'd1, d, dummy);
            a0 = ab8;
            if ((it % 3) == 0) begin
                frame(0, 2'd1, 16'($urandom), int'($urandom_range(0, 7)), rx, bad);
                frame(0, 2'd0, a, -1, rx, bad); model_apply(0, 2'd0, a, dummy);
                checks++;
                if (ab8 - a0 != 1) begin
                    failures++;
                    $display("FAIL rand_abort[%0d]: got %0d cycles want 1", it, ab8 - a0);
                end
            end
            frame(0, 2'd2, a, -1, rx, bad); model_apply(0, 2'd2, a, dummy);
            frame(0, 2'd3, 16'($urandom), -1, rx, bad); model_apply(0, 2'd3, 16'h0, exp);
            checks++;
            if (rx !== exp || bad != 0) begin
                failures++;
                $display("FAIL rand_read[%0d]: got %h bad=%0d want %h bad=0", it, rx, bad, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_abort();
        test_auto_inc();
        test_reset_mid_tx();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
